// File: rtl/maze_pkg.sv
// Shared maze/motion definitions: one-hot direction codes, opposite-direction helper,
// default grid pitch and the sprite motion state encoding.
package maze_pkg;

    localparam logic [3:0] DIR_NONE = 4'b0000;
    localparam logic [3:0] DIR_L    = 4'b0001;
    localparam logic [3:0] DIR_R    = 4'b0010;
    localparam logic [3:0] DIR_U    = 4'b0100;
    localparam logic [3:0] DIR_D    = 4'b1000;

    localparam int TILE_DEF = 8;

    typedef enum logic [1:0] {
        MOVING  = 2'd0,
        STOPPED = 2'd1,
        FROZEN  = 2'd2
    } motion_state_t;

    // L<->R and U<->D swap; DIR_NONE maps to itself
    function automatic logic [3:0] opposite_dir(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

endpackage

// File: rtl/sprite_step_calc.sv
// Combinational next position for one SPEED-pixel step along a one-hot heading,
// with horizontal tunnel wrap between X_MIN and X_MAX. y never wraps.
module sprite_step_calc
    import maze_pkg::*;
#(
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int SPEED = 2,
    parameter int X_MIN = 0,
    parameter int X_MAX = 632
) (
    input  logic [X_W-1:0] x_cur,
    input  logic [Y_W-1:0] y_cur,
    input  logic [3:0]     dir,
    output logic [X_W-1:0] x_next,
    output logic [Y_W-1:0] y_next
);

    // Two guard bits so x-SPEED near zero and x+SPEED near the top never overflow
    localparam int XW2 = X_W + 2;
    localparam logic [XW2-1:0] SPD_X  = XW2'(SPEED);
    localparam logic [XW2-1:0] XMIN_X = XW2'(X_MIN);
    localparam logic [XW2-1:0] XMAX_X = XW2'(X_MAX);
    localparam logic [XW2-1:0] WRAP_L = XW2'(X_MAX + 1 - X_MIN - SPEED);
    localparam logic [XW2-1:0] WRAP_R = XW2'(X_MAX + 1 - X_MIN);

    logic [XW2-1:0] x_ext;
    logic [XW2-1:0] x_inc;

    always_comb begin
        x_ext  = {2'b00, x_cur};
        x_inc  = x_ext + SPD_X;
        x_next = x_cur;
        y_next = y_cur;
        case (dir)
            DIR_L: begin
                if (x_ext < XMIN_X + SPD_X)
                    x_next = X_W'(x_ext + WRAP_L);
                else
                    x_next = X_W'(x_ext - SPD_X);
            end
            DIR_R: begin
                if (x_inc > XMAX_X)
                    x_next = X_W'(x_inc - WRAP_R);
                else
                    x_next = X_W'(x_inc);
            end
            DIR_U:   y_next = y_cur - Y_W'(SPEED);
            DIR_D:   y_next = y_cur + Y_W'(SPEED);
            default: ;
        endcase
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-sprite motion engine: position/heading registers, buffered turn requests applied
// at tile alignment, wall stop, freeze hold and tunnel wrap (via sprite_step_calc).
module sprite_motion_ctrl
    import maze_pkg::*;
#(
    parameter int         X_W      = 10,
    parameter int         Y_W      = 10,
    parameter int         INIT_X   = 360,
    parameter int         INIT_Y   = 154,
    parameter logic [3:0] INIT_DIR = 4'b0001,
    parameter int         SPEED    = 2,
    parameter int         TILE     = TILE_DEF,
    parameter int         X_MIN    = 0,
    parameter int         X_MAX    = 632
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           move_tick,
    input  logic           freeze,
    input  logic [3:0]     req_dir,
    input  logic [3:0]     legal_moves,
    output logic [X_W-1:0] xpos,
    output logic [Y_W-1:0] ypos,
    output logic [3:0]     dir,
    output logic           moving,
    output logic           turn_pending,
    output logic           step_done
);

    localparam int TB = $clog2(TILE);

    motion_state_t state, saved_state, cur_state;
    logic [3:0]     pend_dir, pend_next, req_low, turn_dir;
    logic           aligned, take_turn, blocked;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;

    sprite_step_calc #(
        .X_W   (X_W),
        .Y_W   (Y_W),
        .SPEED (SPEED),
        .X_MIN (X_MIN),
        .X_MAX (X_MAX)
    ) u_step (
        .x_cur  (xpos),
        .y_cur  (ypos),
        .dir    (turn_dir),
        .x_next (x_next),
        .y_next (y_next)
    );

    // A request arriving with move_tick is already visible to that tick's decision
    always_comb begin
        req_low   = req_dir & (~req_dir + 4'd1);
        pend_next = (req_dir != DIR_NONE) ? req_low : pend_dir;
        cur_state = (state == FROZEN) ? saved_state : state;
        aligned   = (xpos[TB-1:0] == '0) && (ypos[TB-1:0] == '0);
        turn_dir  = dir;
        take_turn = 1'b0;
        if (cur_state == STOPPED) begin
            if ((pend_next & legal_moves) != DIR_NONE) begin
                turn_dir  = pend_next;
                take_turn = 1'b1;
            end
        end else if ((pend_next != DIR_NONE) && (pend_next == opposite_dir(dir))) begin
            turn_dir  = pend_next;
            take_turn = 1'b1;
        end else if (aligned && ((pend_next & legal_moves) != DIR_NONE)) begin
            turn_dir  = pend_next;
            take_turn = 1'b1;
        end
        if (cur_state == STOPPED)
            blocked = !take_turn;
        else
            blocked = aligned && ((turn_dir & legal_moves) == DIR_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= MOVING;
            saved_state <= MOVING;
            xpos        <= X_W'(INIT_X);
            ypos        <= Y_W'(INIT_Y);
            dir         <= INIT_DIR;
            pend_dir    <= DIR_NONE;
            step_done   <= 1'b0;
        end else begin
            pend_dir  <= pend_next;
            step_done <= 1'b0;
            if (freeze) begin
                state <= FROZEN;
                if (state != FROZEN)
                    saved_state <= state;
            end else begin
                state <= cur_state;
                if (move_tick) begin
                    step_done <= 1'b1;
                    dir       <= turn_dir;
                    if (take_turn)
                        pend_dir <= DIR_NONE;
                    if (blocked) begin
                        state <= STOPPED;
                    end else begin
                        state <= MOVING;
                        xpos  <= x_next;
                        ypos  <= y_next;
                    end
                end
            end
        end
    end

    assign moving       = (state == MOVING);
    assign turn_pending = (pend_dir != DIR_NONE);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed scenarios plus randomized traffic for sprite_motion_ctrl, checked every
// cycle against a behavioural model of the motion rules.
module tb_sprite_motion_ctrl;

    localparam int X_W = 10, Y_W = 10, SPEED = 2, TILE = 8;
    localparam int X_MIN = 0, X_MAX = 632, INIT_X = 360, INIT_Y = 154;
    localparam logic [3:0] INIT_DIR = 4'b0001;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           move_tick = 1'b0;
    logic           freeze = 1'b0;
    logic [3:0]     req_dir = 4'b0;
    logic [3:0]     legal_moves = 4'b0;
    logic [X_W-1:0] xpos;
    logic [Y_W-1:0] ypos;
    logic [3:0]     dir;
    logic           moving, turn_pending, step_done;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_x, m_y;
    logic [3:0] m_dir, m_pend;
    bit         m_stopped, m_frozen, m_done;
    bit         frz;

    sprite_motion_ctrl #(
        .X_W(X_W), .Y_W(Y_W), .INIT_X(INIT_X), .INIT_Y(INIT_Y), .INIT_DIR(INIT_DIR),
        .SPEED(SPEED), .TILE(TILE), .X_MIN(X_MIN), .X_MAX(X_MAX)
    ) dut (
        .clk(clk), .rst(rst), .move_tick(move_tick), .freeze(freeze),
        .req_dir(req_dir), .legal_moves(legal_moves),
        .xpos(xpos), .ypos(ypos), .dir(dir), .moving(moving),
        .turn_pending(turn_pending), .step_done(step_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] lowest_req(input logic [3:0] r);
        for (int i = 0; i < 4; i++)
            if (r[i]) return 4'(1 << i);
        return 4'b0;
    endfunction

    function automatic logic [3:0] reverse_of(input logic [3:0] d);
        case (d)
            4'b0001: return 4'b0010;
            4'b0010: return 4'b0001;
            4'b0100: return 4'b1000;
            4'b1000: return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_x = INIT_X; m_y = INIT_Y; m_dir = INIT_DIR; m_pend = 4'b0;
        m_stopped = 0; m_frozen = 0; m_done = 0;
    endtask

    task automatic model_move(input logic [3:0] d);
        int nx;
        nx = m_x;
        case (d)
            4'b0001: begin
                nx = m_x - SPEED;
                if (nx < X_MIN) nx = X_MAX + 1 - (X_MIN - nx);
            end
            4'b0010: begin
                nx = m_x + SPEED;
                if (nx > X_MAX) nx = X_MIN + (nx - (X_MAX + 1));
            end
            4'b0100: m_y = (m_y - SPEED + (1 << Y_W)) % (1 << Y_W);
            4'b1000: m_y = (m_y + SPEED) % (1 << Y_W);
            default: ;
        endcase
        m_x = nx;
    endtask

    task automatic model_clock(input bit t, input bit f, input logic [3:0] r, input logic [3:0] l);
        bit         al;
        logic [3:0] nd;
        al = (m_x % TILE == 0) && (m_y % TILE == 0);
        if (r != 4'b0) m_pend = lowest_req(r);
        m_done = 0;
        if (f) begin
            m_frozen = 1;
        end else begin
            m_frozen = 0;
            if (t) begin
                m_done = 1;
                if (m_stopped) begin
                    if ((m_pend & l) != 0) begin
                        m_dir = m_pend; m_pend = 0; m_stopped = 0;
                        model_move(m_dir);
                    end
                end else begin
                    nd = m_dir;
                    if (m_pend != 0 && m_pend == reverse_of(m_dir)) begin
                        nd = m_pend; m_pend = 0;
                    end else if (al && (m_pend & l) != 0) begin
                        nd = m_pend; m_pend = 0;
                    end
                    m_dir = nd;
                    if (al && (nd & l) == 0) m_stopped = 1;
                    else model_move(nd);
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("xpos", 32'(xpos), 32'(m_x));
        chk("ypos", 32'(ypos), 32'(m_y));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("moving", 32'(moving), 32'(!m_stopped && !m_frozen));
        chk("turn_pending", 32'(turn_pending), 32'(m_pend != 0));
        chk("step_done", 32'(step_done), 32'(m_done));
    endtask

    // Called from a negedge; leaves the bench at the following negedge
    task automatic cyc(input bit t, input bit f, input logic [3:0] r, input logic [3:0] l);
        move_tick = t; freeze = f; req_dir = r; legal_moves = l;
        @(posedge clk);
        model_clock(t, f, r, l);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        move_tick = 0; freeze = 0; req_dir = 0;
        #2 rst = 1'b1;
        #1 model_reset();
        chk("rst_async_x", 32'(xpos), 32'(INIT_X));
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_x", 32'(xpos), 32'd360);
        chk("rst_y", 32'(ypos), 32'd154);
        chk("rst_dir", 32'(dir), 32'd1);
        chk("rst_moving", 32'(moving), 32'd1);
        chk("rst_pending", 32'(turn_pending), 32'd0);
        chk("rst_step_done", 32'(step_done), 32'd0);

        cyc(1, 0, 4'b0000, 4'b0011);
        chk("first_step", 32'(xpos), 32'd358);
        cyc(0, 0, 4'b0000, 4'b0011);
        chk("done_once", 32'(step_done), 32'd0);
        cyc(1, 0, 4'b0000, 4'b0011);
        chk("second_step", 32'(xpos), 32'd356);
        cyc(0, 0, 4'b0100, 4'b0111);
        chk("buffered_pending", 32'(turn_pending), 32'd1);
        cyc(0, 0, 4'b0000, 4'b0111);
        cyc(1, 0, 4'b0010, 4'b0111);
        chk("reverse_dir", 32'(dir), 32'd2);
        chk("reverse_x", 32'(xpos), 32'd358);
        cyc(1, 0, 4'b0001, 4'b0001);
        chk("reverse_back", 32'(xpos), 32'd356);

        for (int i = 0; i < 178; i++) cyc(1, 0, 4'b0000, 4'b0001);
        chk("tunnel_at_zero", 32'(xpos), 32'd0);
        cyc(1, 0, 4'b0000, 4'b0001);
        chk("tunnel_wrap_left", 32'(xpos), 32'd631);
        cyc(1, 0, 4'b0010, 4'b0011);
        chk("tunnel_wrap_right", 32'(xpos), 32'd0);

        for (int i = 0; i < 10; i++) cyc(1, 1, (i == 3) ? 4'b1100 : 4'b0000, 4'b1111);
        chk("freeze_hold_x", 32'(xpos), 32'd0);
        chk("freeze_moving", 32'(moving), 32'd0);
        chk("freeze_latch", 32'(turn_pending), 32'd1);
        freeze = 1;
        do_reset();
        chk("rst_frozen_x", 32'(xpos), 32'd360);
        chk("rst_frozen_pend", 32'(turn_pending), 32'd0);
        chk("rst_frozen_moving", 32'(moving), 32'd1);

        frz = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] r;
            if ($urandom_range(0, 15) == 0) frz = !frz;
            r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            cyc(1'($urandom_range(0, 1)), frz, r, 4'($urandom));
            if (i == 2000) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
